// File: rtl/spi_xip_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// spi_xip_pkg -- register map, CTRL fields and sequencer states for spi_xip_ctrl
// Rev 1.0
// ----------------------------------------------------------------------------
package spi_xip_pkg;

  localparam logic [4:0] REG_RX0  = 5'h00;
  localparam logic [4:0] REG_TX1  = 5'h04;
  localparam logic [4:0] REG_CTRL = 5'h10;
  localparam logic [4:0] REG_DIV  = 5'h14;
  localparam logic [4:0] REG_SS   = 5'h18;

  localparam int CTRL_GO_BSY = 8;
  localparam int CTRL_TX_NEG = 10;
  localparam int CTRL_ASS    = 13;

  localparam logic [7:0]  OP_READ      = 8'h03;
  localparam logic [31:0] XIP_CHAR_LEN = 32'd64;

  // 64-bit frame: opcode + 24-bit address out, 32 data bits back; SS driven manually
  localparam logic [31:0] XIP_CTRL_GO = (XIP_CHAR_LEN | (32'h1 << CTRL_GO_BSY) |
                                         (32'h1 << CTRL_TX_NEG)) & ~(32'h1 << CTRL_ASS);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ERR,
    ST_TX1,
    ST_DIV,
    ST_SS,
    ST_GO,
    ST_POLL,
    ST_RX,
    ST_SSCLR,
    ST_RESP
  } xip_state_t;

  function automatic logic [31:0] byte_swap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_wb_req.sv
`default_nettype none
// ----------------------------------------------------------------------------
// spi_wb_req -- single-access registered Wishbone master with a done pulse
// Rev 1.0
// ----------------------------------------------------------------------------
module spi_wb_req (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [4:0]  wb_adr,
  output logic [31:0] wb_dat,
  output logic        wb_we,
  output logic        wb_stb,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack,
  input  logic        wb_err
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wb_adr <= '0;
      wb_dat <= '0;
      wb_we  <= 1'b0;
      wb_stb <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      rdata  <= '0;
    end else begin
      done <= 1'b0;
      if (!wb_stb) begin
        if (start) begin
          wb_stb <= 1'b1;
          wb_adr <= addr;
          wb_dat <= wdata;
          wb_we  <= we;
          err    <= 1'b0;
        end
      end else if (wb_ack || wb_err) begin
        wb_stb <= 1'b0;
        done   <= 1'b1;
        err    <= wb_err;
        rdata  <= wb_dat_i;
      end
    end
  end

  assign busy = wb_stb;

endmodule
`default_nettype wire

// File: rtl/spi_xip_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// spi_xip_ctrl -- APB front end for spi_top: register pass-through and XIP reads
// Rev 1.0
// ----------------------------------------------------------------------------
module spi_xip_ctrl
  import spi_xip_pkg::*;
#(
  parameter logic [31:0] FLASH_BASE  = 32'h3000_0000,
  parameter logic [31:0] FLASH_END   = 32'h3fff_ffff,
  parameter logic [31:0] SPI_BASE    = 32'h1000_1000,
  parameter logic [31:0] SPI_END     = 32'h1000_1fff,
  parameter logic [31:0] XIP_DIVIDER = 32'h1,
  parameter int          POLL_MAX    = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] in_paddr,
  input  logic        in_psel,
  input  logic        in_penable,
  input  logic        in_pwrite,
  input  logic [2:0]  in_pprot,
  input  logic [31:0] in_pwdata,
  input  logic [3:0]  in_pstrb,
  output logic        in_pready,
  output logic [31:0] in_prdata,
  output logic        in_pslverr,
  output logic [4:0]  wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  localparam int PW = $clog2(POLL_MAX + 1);

  xip_state_t  state, state_nxt;
  logic [23:0] flash_addr;
  logic [31:0] rx_word;
  logic        err_flag;
  logic [PW-1:0] poll_cnt;

  logic        access, spi_hit, flash_hit, pass, poll_last, poll_busy, seq_state;
  logic        req_start, req_busy, req_done, req_err, req_we_in;
  logic [4:0]  req_addr_in;
  logic [31:0] req_wdata_in, req_rdata;
  logic [4:0]  req_adr;
  logic [31:0] req_dat;
  logic        req_we, req_stb;
  logic        unused;

  assign unused    = ^in_pprot;
  assign access    = in_psel & in_penable;
  assign spi_hit   = (in_paddr >= SPI_BASE) && (in_paddr <= SPI_END);
  assign flash_hit = (in_paddr >= FLASH_BASE) && (in_paddr <= FLASH_END);
  assign pass      = (state == ST_IDLE) & ~reset & in_psel & spi_hit;
  assign poll_last = (poll_cnt == PW'(POLL_MAX - 1));
  assign poll_busy = (state == ST_POLL) & req_done & ~req_err & req_rdata[CTRL_GO_BSY];
  assign seq_state = (state inside {ST_TX1, ST_DIV, ST_SS, ST_GO, ST_POLL, ST_RX, ST_SSCLR});
  // a new access is issued only once the previous done pulse has been consumed
  assign req_start = seq_state & ~req_busy & ~req_done;

  always_comb begin
    req_addr_in  = REG_SS;
    req_wdata_in = '0;
    req_we_in    = 1'b1;
    case (state)
      ST_TX1:  begin req_addr_in = REG_TX1;  req_wdata_in = {OP_READ, flash_addr}; end
      ST_DIV:  begin req_addr_in = REG_DIV;  req_wdata_in = XIP_DIVIDER; end
      ST_SS:   begin req_addr_in = REG_SS;   req_wdata_in = 32'h1; end
      ST_GO:   begin req_addr_in = REG_CTRL; req_wdata_in = XIP_CTRL_GO; end
      ST_POLL: begin req_addr_in = REG_CTRL; req_we_in = 1'b0; end
      ST_RX:   begin req_addr_in = REG_RX0;  req_we_in = 1'b0; end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:
        if (access && !spi_hit)
          state_nxt = (flash_hit && !in_pwrite) ? ST_TX1 : ST_ERR;
      ST_ERR, ST_RESP:
        state_nxt = ST_IDLE;
      default:
        if (req_done) begin
          if (req_err)
            state_nxt = (state == ST_SSCLR) ? ST_RESP : ST_SSCLR;
          else begin
            case (state)
              ST_TX1:   state_nxt = ST_DIV;
              ST_DIV:   state_nxt = ST_SS;
              ST_SS:    state_nxt = ST_GO;
              ST_GO:    state_nxt = ST_POLL;
              ST_POLL:  if (!req_rdata[CTRL_GO_BSY]) state_nxt = ST_RX;
                        else if (poll_last)          state_nxt = ST_SSCLR;
              ST_RX:    state_nxt = ST_SSCLR;
              ST_SSCLR: state_nxt = ST_RESP;
              default:  state_nxt = ST_IDLE;
            endcase
          end
        end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      flash_addr <= '0;
      rx_word    <= '0;
      err_flag   <= 1'b0;
      poll_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && state_nxt == ST_TX1) begin
        flash_addr <= in_paddr[23:0];
        rx_word    <= '0;
        err_flag   <= 1'b0;
      end
      if (state == ST_GO)
        poll_cnt <= '0;
      if (poll_busy)
        poll_cnt <= poll_cnt + 1'b1;
      if ((req_done && req_err) || (poll_busy && poll_last))
        err_flag <= 1'b1;
      if (state == ST_RX && req_done && !req_err)
        rx_word <= byte_swap(req_rdata);
    end
  end

  spi_wb_req u_req (
    .clock    (clock),
    .reset    (reset),
    .start    (req_start),
    .addr     (req_addr_in),
    .wdata    (req_wdata_in),
    .we       (req_we_in),
    .busy     (req_busy),
    .done     (req_done),
    .err      (req_err),
    .rdata    (req_rdata),
    .wb_adr   (req_adr),
    .wb_dat   (req_dat),
    .wb_we    (req_we),
    .wb_stb   (req_stb),
    .wb_dat_i (wb_dat_i),
    .wb_ack   (wb_ack_i),
    .wb_err   (wb_err_i)
  );

  assign wb_adr_o   = pass ? in_paddr[4:0] : req_adr;
  assign wb_dat_o   = pass ? in_pwdata     : req_dat;
  assign wb_sel_o   = pass ? in_pstrb      : {4{req_stb}};
  assign wb_we_o    = pass ? in_pwrite     : req_we;
  assign wb_stb_o   = pass ? access        : req_stb;
  assign wb_cyc_o   = pass ? access        : req_stb;
  assign in_pready  = pass ? (access & (wb_ack_i | wb_err_i))
                           : ((state == ST_ERR) || (state == ST_RESP));
  assign in_prdata  = pass ? wb_dat_i : ((state == ST_RESP) ? rx_word : 32'h0);
  assign in_pslverr = pass ? (access & wb_err_i)
                           : ((state == ST_ERR) || ((state == ST_RESP) && err_flag));

endmodule
`default_nettype wire
